// File: rtl/btn_pkg.sv
// Shared types for the multi-button debouncer: the per-channel FSM state encoding.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

endpackage : btn_pkg

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser chain, 4-state stability FSM and
// long-press timer, with all outputs registered.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int LONG_CYCLES   = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);

  // The long timer stops at LONG_CYCLES so it can never wrap into a second pulse.
  function automatic logic [LONG_W-1:0] sat_inc(input logic [LONG_W-1:0] v);
    return (v == LONG_W'(LONG_CYCLES)) ? v : v + LONG_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  btn_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LONG_W-1:0]      long_q;
  logic [LONG_W-1:0]      long_d;
  logic                   long_hit_d;
  logic                   level_q, rise_q, fall_q, long_pulse_q;
  logic                   s;
  logic                   cnt_done;

  assign s          = sync_q[SYNC_STAGES-1];
  assign cnt_done   = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign long_d     = sat_inc(long_q);
  assign long_hit_d = (long_q == LONG_W'(LONG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= LOW;
      cnt_q        <= '0;
      long_q       <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], btn_i};
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      long_pulse_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_done) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            long_q  <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          long_q       <= long_d;
          long_pulse_q <= long_hit_d;
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          // A bounce back to 1 resumes HIGH without disturbing the long timer.
          if (s) begin
            state_q      <= HIGH;
            cnt_q        <= '0;
            long_q       <= long_d;
            long_pulse_q <= long_hit_d;
          end else if (cnt_done) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            long_q  <= '0;
          end else begin
            cnt_q        <= cnt_q + CNT_W'(1);
            long_q       <= long_d;
            long_pulse_q <= long_hit_d;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_pulse_q;

endmodule : debounce_channel

// File: rtl/multi_btn_debouncer.sv
// N_BTN independent button debouncers with level, edge and long-press outputs.
module multi_btn_debouncer #(
  parameter int N_BTN         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int LONG_CYCLES   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_rise,
  output logic [N_BTN-1:0] o_fall,
  output logic [N_BTN-1:0] o_long
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (reset),
      .btn_i  (i_btn[g]),
      .level_o(o_level[g]),
      .rise_o (o_rise[g]),
      .fall_o (o_fall[g]),
      .long_o (o_long[g])
    );
  end

endmodule : multi_btn_debouncer
